// File: rtl/neokeon_decrypt_core_pkg.sv
// Shared constants, FSM encoding and NOEKEON round primitives for the decryption core.
package neokeon_decrypt_core_pkg;

  localparam int          NR       = 16;
  localparam logic [7:0]  RC_FIRST = 8'h80;
  localparam logic [7:0]  RC_LAST  = 8'hD4;
  localparam logic [7:0]  RC_POLY  = 8'h1B;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEY   = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } fsm_state_e;

  // Word order: a0 lives in [127:96], a3 in [31:0].
  function automatic logic [31:0] word_of(input logic [127:0] blk, input int unsigned idx);
    return blk[127 - 32*idx -: 32];
  endfunction

  function automatic logic [127:0] rc_word0(input logic [7:0] rc);
    return {24'h0, rc, 96'h0};
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [127:0] theta(input logic [127:0] s, input logic [127:0] k);
    logic [31:0] a0, a1, a2, a3, t;
    a0 = word_of(s, 0);
    a1 = word_of(s, 1);
    a2 = word_of(s, 2);
    a3 = word_of(s, 3);
    t  = a0 ^ a2;
    t  = t ^ rotl32(t, 8) ^ rotr32(t, 8);
    a1 = a1 ^ t;
    a3 = a3 ^ t;
    a0 = a0 ^ word_of(k, 0);
    a1 = a1 ^ word_of(k, 1);
    a2 = a2 ^ word_of(k, 2);
    a3 = a3 ^ word_of(k, 3);
    t  = a1 ^ a3;
    t  = t ^ rotl32(t, 8) ^ rotr32(t, 8);
    a0 = a0 ^ t;
    a2 = a2 ^ t;
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [127:0] pi1(input logic [127:0] s);
    return {word_of(s, 0), rotl32(word_of(s, 1), 1), rotl32(word_of(s, 2), 5),
            rotl32(word_of(s, 3), 2)};
  endfunction

  function automatic logic [127:0] pi2(input logic [127:0] s);
    return {word_of(s, 0), rotr32(word_of(s, 1), 1), rotr32(word_of(s, 2), 5),
            rotr32(word_of(s, 3), 2)};
  endfunction

  function automatic logic [127:0] gamma(input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, tmp;
    a0  = word_of(s, 0);
    a1  = word_of(s, 1);
    a2  = word_of(s, 2);
    a3  = word_of(s, 3);
    a1  = a1 ^ (~a3 & ~a2);
    a0  = a0 ^ (a2 & a1);
    tmp = a0;
    a0  = a3;
    a3  = tmp;
    a2  = a2 ^ a0 ^ a1 ^ a3;
    a1  = a1 ^ (~a3 & ~a2);
    a0  = a0 ^ (a2 & a1);
    return {a0, a1, a2, a3};
  endfunction

  // Walks the encryption constant schedule backwards.
  function automatic logic [7:0] inv_xtime(input logic [7:0] rc);
    return rc[0] ? (((rc ^ RC_POLY) >> 1) | 8'h80) : (rc >> 1);
  endfunction

endpackage

// File: rtl/neokeon_round_fun.sv
// Combinational NOEKEON round: c1 before Theta, c2 after, then Pi1, Gamma, Pi2.
// theta_out is plain Theta(state, key), used for key derivation and the output transform.
module neokeon_round_fun
  import neokeon_decrypt_core_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [7:0]   c1,
  input  logic [7:0]   c2,
  output logic [127:0] theta_out,
  output logic [127:0] round_out
);

  logic [127:0] mixed;

  assign theta_out = theta(state, key);
  assign mixed     = theta(state ^ rc_word0(c1), key) ^ rc_word0(c2);
  assign round_out = pi2(gamma(pi1(mixed)));

endmodule

// File: rtl/neokeon_decrypt_core.sv
// Iterative NOEKEON-128 decryption (direct key), one round per clock, valid/ready on both sides.
//   state   | meaning
//   S_IDLE  | outReady high, waiting for inValid
//   S_KEY   | derive working key Theta(0, key)
//   S_ROUND | 16 rounds with rc walking D4 -> 1B
//   S_FINAL | output transform Theta(state, key) ^ rc(80)
//   S_DONE  | hold plaintext until inReadyOut
module neokeon_decrypt_core
  import neokeon_decrypt_core_pkg::*;
(
  input  logic         inClk,
  input  logic         inReset,
  input  logic         inValid,
  output logic         outReady,
  input  logic [127:0] inKey,
  input  logic [127:0] inDataBlock,
  output logic         outValid,
  input  logic         inReadyOut,
  output logic [127:0] outDataBlock
);

  fsm_state_e   fsm;
  logic [127:0] blk;
  logic [127:0] key;
  logic [7:0]   rc;
  logic [3:0]   round_cnt;

  logic [127:0] rf_state;
  logic [127:0] rf_key;
  logic [127:0] theta_out;
  logic [127:0] round_out;

  // The KEY cycle runs Theta on the key itself with an all-zero key vector.
  assign rf_state = (fsm == S_KEY) ? key : blk;
  assign rf_key   = (fsm == S_KEY) ? 128'h0 : key;

  neokeon_round_fun u_round (
    .state     (rf_state),
    .key       (rf_key),
    .c1        (8'h00),
    .c2        (rc),
    .theta_out (theta_out),
    .round_out (round_out)
  );

  always_ff @(posedge inClk) begin
    if (inReset) begin
      fsm          <= S_IDLE;
      blk          <= 128'h0;
      key          <= 128'h0;
      rc           <= 8'h00;
      round_cnt    <= 4'd0;
      outReady     <= 1'b1;
      outValid     <= 1'b0;
      outDataBlock <= 128'h0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (inValid) begin
            blk       <= inDataBlock;
            key       <= inKey;
            rc        <= RC_LAST;
            round_cnt <= 4'd0;
            outReady  <= 1'b0;
            fsm       <= S_KEY;
          end
        end
        S_KEY: begin
          key <= theta_out;
          fsm <= S_ROUND;
        end
        S_ROUND: begin
          blk       <= round_out;
          rc        <= inv_xtime(rc);
          round_cnt <= round_cnt + 4'd1;
          if (round_cnt == 4'(NR - 1)) fsm <= S_FINAL;
        end
        S_FINAL: begin
          outDataBlock <= theta_out ^ rc_word0(rc);
          outValid     <= 1'b1;
          fsm          <= S_DONE;
        end
        S_DONE: begin
          if (inReadyOut) begin
            outValid <= 1'b0;
            outReady <= 1'b1;
            fsm      <= S_IDLE;
          end
        end
        default: begin
          outValid <= 1'b0;
          outReady <= 1'b1;
          fsm      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neokeon_decrypt_core.sv
// Scoreboard bench: a reference NOEKEON encryptor builds ciphertexts, the expected plaintext is queued.
module tb_neokeon_decrypt_core;

  logic         inClk = 1'b0;
  logic         inReset = 1'b1;
  logic         inValid = 1'b0;
  logic         outReady;
  logic [127:0] inKey = '0;
  logic [127:0] inDataBlock = '0;
  logic         outValid;
  logic         inReadyOut = 1'b1;
  logic [127:0] outDataBlock;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;
  logic [127:0] exp_q[$];

  always #5 inClk = ~inClk;

  neokeon_decrypt_core dut (
    .inClk        (inClk),
    .inReset      (inReset),
    .inValid      (inValid),
    .outReady     (outReady),
    .inKey        (inKey),
    .inDataBlock  (inDataBlock),
    .outValid     (outValid),
    .inReadyOut   (inReadyOut),
    .outDataBlock (outDataBlock)
  );

  // ---------------- reference model (encryption direction) ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [127:0] m_theta(input logic [127:0] s, input logic [127:0] k);
    logic [31:0] a[4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) a[i] = s[127 - 32*i -: 32];
    t = a[0] ^ a[2];
    t = t ^ rl(t, 8) ^ rl(t, 24);
    a[1] ^= t;
    a[3] ^= t;
    for (int i = 0; i < 4; i++) a[i] ^= k[127 - 32*i -: 32];
    t = a[1] ^ a[3];
    t = t ^ rl(t, 8) ^ rl(t, 24);
    a[0] ^= t;
    a[2] ^= t;
    return {a[0], a[1], a[2], a[3]};
  endfunction

  function automatic logic [127:0] m_round(input logic [127:0] s, input logic [127:0] k,
                                           input logic [7:0] r);
    logic [31:0] a[4];
    logic [31:0] tmp;
    logic [127:0] x;
    x = m_theta(s ^ {24'h0, r, 96'h0}, k);
    for (int i = 0; i < 4; i++) a[i] = x[127 - 32*i -: 32];
    a[1] = rl(a[1], 1); a[2] = rl(a[2], 5); a[3] = rl(a[3], 2);
    a[1] ^= ~a[3] & ~a[2];
    a[0] ^= a[2] & a[1];
    tmp = a[0]; a[0] = a[3]; a[3] = tmp;
    a[2] ^= a[0] ^ a[1] ^ a[3];
    a[1] ^= ~a[3] & ~a[2];
    a[0] ^= a[2] & a[1];
    a[1] = rl(a[1], 31); a[2] = rl(a[2], 27); a[3] = rl(a[3], 30);
    return {a[0], a[1], a[2], a[3]};
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] s;
    logic [7:0] r;
    s = pt;
    r = 8'h80;
    for (int i = 0; i < 16; i++) begin
      s = m_round(s, k, r);
      r = xt(r);
    end
    s = s ^ {24'h0, r, 96'h0};
    return m_theta(s, k);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: a handshake completes on the next rising edge.
  always @(negedge inClk) begin
    #1;
    if (!inReset && outValid && inReadyOut) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h with empty scoreboard", outDataBlock);
      end else begin
        check("plaintext", outDataBlock, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [127:0] pt, input logic [127:0] k, input bit hold);
    bit ready_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge inClk);
      if (outReady) begin
        ready_seen = 1;
        break;
      end
    end
    check("accept_timeout", 128'(ready_seen), 128'd1);
    inKey       = k;
    inDataBlock = model_encrypt(pt, k);
    inValid     = 1'b1;
    @(posedge inClk);
    if (ready_seen) exp_q.push_back(pt);
    #1;
    if (!hold) inValid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge inClk);
      if (exp_q.size() == 0 && outReady) begin
        done = 1;
        break;
      end
    end
    check("drain_timeout", 128'(done), 128'd1);
  endtask

  logic [7:0] rc_exp [17] = '{8'hD4, 8'h6A, 8'h35, 8'h97, 8'hC6, 8'h63, 8'hBC, 8'h5E, 8'h2F,
                              8'h9A, 8'h4D, 8'hAB, 8'hD8, 8'h6C, 8'h36, 8'h1B, 8'h80};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] pt;
    logic [127:0] k;
    int cyc;
    int hs_before;
    bit phantom;

    // Reset state
    repeat (3) @(posedge inClk);
    @(negedge inClk);
    inReset = 1'b0;
    check("reset_ready", 128'(outReady), 128'd1);
    check("reset_valid", 128'(outValid), 128'd0);
    check("reset_data", outDataBlock, 128'h0);
    check("reset_rc", 128'(dut.rc), 128'h0);

    // 1: round trip of the zero block under the zero key, with latency
    send(128'h0, 128'h0, 0);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge inClk);
      #1;
      if (outValid) begin
        cyc = i;
        break;
      end
    end
    check("latency", 128'(cyc), 128'd18);
    drain();

    // 2: known answer
    send(128'h00112233445566778899AABBCCDDEEFF, 128'h000102030405060708090A0B0C0D0E0F, 0);
    drain();

    // 3: round-constant trace
    send(rand128(), rand128(), 0);
    for (int j = 0; j < 17; j++) begin
      @(posedge inClk);
      #1;
      check($sformatf("rc_trace_%0d", j), 128'(dut.rc), 128'(rc_exp[j]));
    end
    drain();

    // 4: backpressure with ignored inValid pulses
    inReadyOut = 1'b0;
    pt = rand128();
    k  = rand128();
    send(pt, k, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge inClk);
      if (outValid) break;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge inClk);
      check("bp_data", outDataBlock, pt);
      check("bp_valid", 128'(outValid), 128'd1);
      check("bp_ready", 128'(outReady), 128'd0);
      inValid     = i[0];
      inDataBlock = rand128();
      inKey       = rand128();
    end
    inValid    = 1'b0;
    inReadyOut = 1'b1;
    drain();
    phantom = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge inClk);
      if (outValid || !outReady) phantom = 1;
    end
    check("bp_no_phantom", 128'(phantom), 128'd0);

    // 5: reset in the middle of the rounds
    send(rand128(), rand128(), 0);
    repeat (8) @(posedge inClk);
    @(negedge inClk);
    exp_q.delete();
    inReset = 1'b1;
    @(posedge inClk);
    #1;
    inReset = 1'b0;
    check("midrst_ready", 128'(outReady), 128'd1);
    check("midrst_valid", 128'(outValid), 128'd0);
    check("midrst_data", outDataBlock, 128'h0);
    send(rand128(), rand128(), 0);
    drain();

    // 6: back-to-back with inValid held high
    hs_before = hs_count;
    for (int b = 0; b < 3; b++) send(rand128(), rand128(), 1);
    inValid = 1'b0;
    drain();
    check("b2b_count", 128'(hs_count - hs_before), 128'd3);

    // a few more random blocks, each under its own key
    for (int b = 0; b < 4; b++) begin
      send(rand128(), rand128(), 0);
      drain();
    end

    repeat (5) @(negedge inClk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
